fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, the first fetch address after reset (word-aligned).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port fetch_en  input  1  when high, controller runs; when low, no new fetches are issued.
REQ-005 SHALL have port imem_addr  output  32  byte address to the combinational instruction memory; equals the PC register.
REQ-006 SHALL have port imem_instr  input  32  instruction word returned combinationally for imem_addr in the same cycle.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump redirect request from execute.
REQ-008 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-009 SHALL have port out_valid  output  1  head of fetch buffer holds a valid instruction.
REQ-010 SHALL have port out_ready  input  1  decode accepts the head entry.
REQ-011 SHALL have port out_pc  output  32  PC of head entry.
REQ-012 SHALL have port out_instr  output  32  instruction word of head entry.
REQ-013 SHALL have port misalign_err  output  1  sticky flag: a redirect target had bits[1:0] != 0.

Function
REQ-014 SHALL implement states IDLE, RUN, ERROR.
REQ-015 SHALL transition IDLE->RUN when fetch_en=1 and RUN->IDLE when fetch_en=0; redirect does not change IDLE/RUN state.
REQ-016 SHALL contain a 2-entry FIFO of {pc, instr} with count 0..2; out_valid = (count != 0); out_pc/out_instr come from the head entry.
REQ-017 SHALL pop the head when out_valid && out_ready.
REQ-018 SHALL push {PC, imem_instr} and advance PC by 4 in any cycle where state=RUN, redirect_valid=0, and (count<2 or pop occurs this cycle).
REQ-019 SHALL allow simultaneous push and pop, including while count=2; count is then unchanged and FIFO order is preserved.
REQ-020 SHALL hold PC and push nothing when the FIFO is full without a pop (backpressure), in IDLE, or in ERROR.
REQ-021 SHALL compute PC+4 modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-022 SHALL, on redirect_valid=1 with redirect_pc[1:0]==2'b00 in IDLE or RUN: flush the FIFO (count<=0), load PC<=redirect_pc, push nothing, and ignore out_ready that cycle; redirect has priority over push and pop.
REQ-023 SHALL, on redirect_valid=1 with redirect_pc[1:0]!=2'b00 in IDLE or RUN: flush the FIFO, leave PC unchanged, set misalign_err<=1, and enter ERROR.
REQ-024 SHALL remain in ERROR with out_valid=0 and no fetches until reset; redirects in ERROR are ignored.
REQ-025 SHALL produce the first instruction at the redirect target with out_valid=1 in the cycle after the first push following the redirect (minimum redirect-to-valid latency 2 cycles when in RUN).
REQ-026 SHALL keep draining FIFO contents via out_ready while in IDLE.
REQ-027 SHALL drive out_pc/out_instr to 0 when out_valid=0.

Reset
REQ-028 SHALL, while rst_n=0 (asynchronous to clk): state=IDLE, PC=RESET_PC, count=0, out_valid=0, out_pc=0, out_instr=0, misalign_err=0; imem_addr=RESET_PC.
REQ-029 SHALL discard all buffered entries on reset asserted mid-operation; the first fetch after release is from RESET_PC.
REQ-030 SHALL resume operation on the first rising clk edge after rst_n deasserts, with fetch_en sampled on that edge.

Verification
REQ-031 Streaming: reset, fetch_en=1, out_ready=1 constantly -> out_pc 0x0,0x4,0x8,... on consecutive cycles starting 2 cycles after the first edge, with out_instr matching memory.
REQ-032 Backpressure: out_ready=0 for 5 cycles -> count saturates at 2, PC holds at 0x8, out_pc stays 0x0; out_ready=1 -> 0x0,0x4,0x8 delivered in order with no gap or duplicate.
REQ-033 Redirect: redirect_pc=0x00000040 while entries are buffered -> buffered entries never appear, out_valid=0 for 1 cycle, next out_pc=0x40, then 0x44.
REQ-034 Misaligned: redirect_pc=0x00000042 -> misalign_err=1 next cycle, out_valid=0 permanently, imem_addr frozen; rst_n pulse clears misalign_err and restarts at RESET_PC.
REQ-035 Wrap/pause: redirect to 0xFFFFFFF8 -> out_pc 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; fetch_en=0 -> no new pushes, remaining entries still drain.
REQ-036 Async reset mid-stream: rst_n low between clock edges with count=2 -> out_valid=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/fetch_controller.sv
// Instruction fetch front end: PC register, combinational imem lookup, 2-entry
// {pc, instr} buffer toward decode, redirect handling and a sticky misalignment trap.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        misalign_err
);

  typedef enum logic [1:0] {IDLE, RUN, ERROR} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_t            state, state_nxt;
  logic [31:0]       pc, pc_nxt;
  entry_t [1:0]      fifo, fifo_nxt;
  logic [1:0]        count, count_nxt;
  logic              err_nxt;
  entry_t            new_ent;
  logic              live, redir_ok, redir_bad, flush, pop, push;

  // Redirects are only honoured outside ERROR; either kind flushes the buffer.
  assign live      = (state != ERROR);
  assign redir_ok  = live && redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign redir_bad = live && redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign flush     = redir_ok || redir_bad;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready && !flush;
  assign push      = (state == RUN) && !redirect_valid && ((count != 2'd2) || pop);
  assign new_ent   = '{pc: pc, instr: imem_instr};

  assign imem_addr = pc;
  assign out_pc    = out_valid ? fifo[0].pc    : 32'h0;
  assign out_instr = out_valid ? fifo[0].instr : 32'h0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (redir_bad) state_nxt = ERROR;
               else if (fetch_en) state_nxt = RUN;
      RUN:     if (redir_bad) state_nxt = ERROR;
               else if (!fetch_en) state_nxt = IDLE;
      ERROR:   state_nxt = ERROR;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pc_nxt    = pc;
    fifo_nxt  = fifo;
    count_nxt = count;
    err_nxt   = misalign_err;
    if (flush) begin
      count_nxt = 2'd0;
      if (redir_ok) pc_nxt  = redirect_pc;
      else          err_nxt = 1'b1;
    end else begin
      if (push) pc_nxt = pc + 32'd4;
      // Slot 0 is always the head; slot 1 only meaningful when count == 2.
      case ({push, pop})
        2'b10: begin
          fifo_nxt[count[0]] = new_ent;
          count_nxt          = count + 2'd1;
        end
        2'b01: begin
          fifo_nxt[0] = fifo[1];
          count_nxt   = count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            fifo_nxt[0] = new_ent;
          end else begin
            fifo_nxt[0] = fifo[1];
            fifo_nxt[1] = new_ent;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      fifo         <= '0;
      count        <= 2'd0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      fifo         <= fifo_nxt;
      count        <= count_nxt;
      misalign_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed vector bench for fetch_controller: streaming, backpressure, redirect,
// wrap, pause/drain, misalignment trap and asynchronous reset.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en, redirect_valid, out_ready;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_instr, out_pc, out_instr;
  logic        out_valid, misalign_err;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  assign imem_instr = mem(imem_addr);

  always #5 clk = ~clk;

  fetch_controller dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .misalign_err(misalign_err)
  );

  typedef struct {
    logic        fe, rdy, rv;
    logic [31:0] rpc;
    logic        ov;
    logic [31:0] opc, addr;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic fe, rdy, rv, input logic [31:0] rpc,
                              input logic ov, input logic [31:0] opc, addr, input logic err);
    vec_t v;
    v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ov = ov; v.opc = opc; v.addr = addr; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic expect_out(input string nm, input int idx, input logic ov,
                            input logic [31:0] opc, addr, input logic err);
    n_vec++;
    chk({nm, ".out_valid"},    idx, {31'b0, out_valid},    {31'b0, ov});
    chk({nm, ".out_pc"},       idx, out_pc,                ov ? opc : 32'h0);
    chk({nm, ".out_instr"},    idx, out_instr,             ov ? mem(opc) : 32'h0);
    chk({nm, ".imem_addr"},    idx, imem_addr,             addr);
    chk({nm, ".misalign_err"}, idx, {31'b0, misalign_err}, {31'b0, err});
  endtask

  task automatic step(input logic fe, rdy, rv, input logic [31:0] rpc);
    fetch_en = fe; out_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // streaming
    tbl.push_back(mk(1,1,0,0, 0,32'h0,       32'h0,       0));
    tbl.push_back(mk(1,1,0,0, 1,32'h0,       32'h4,       0));
    tbl.push_back(mk(1,1,0,0, 1,32'h4,       32'h8,       0));
    tbl.push_back(mk(1,1,0,0, 1,32'h8,       32'hC,       0));
    // backpressure for 5 cycles, then drain in order
    tbl.push_back(mk(1,0,0,0, 1,32'h8,       32'h10,      0));
    tbl.push_back(mk(1,0,0,0, 1,32'h8,       32'h10,      0));
    tbl.push_back(mk(1,0,0,0, 1,32'h8,       32'h10,      0));
    tbl.push_back(mk(1,0,0,0, 1,32'h8,       32'h10,      0));
    tbl.push_back(mk(1,0,0,0, 1,32'h8,       32'h10,      0));
    tbl.push_back(mk(1,1,0,0, 1,32'hC,       32'h14,      0));
    tbl.push_back(mk(1,1,0,0, 1,32'h10,      32'h18,      0));
    tbl.push_back(mk(1,1,0,0, 1,32'h14,      32'h1C,      0));
    // redirect with a full buffer
    tbl.push_back(mk(1,1,1,32'h40, 0,32'h0,  32'h40,      0));
    tbl.push_back(mk(1,1,0,0, 1,32'h40,      32'h44,      0));
    tbl.push_back(mk(1,1,0,0, 1,32'h44,      32'h48,      0));
    // wrap around the top of the address space
    tbl.push_back(mk(1,1,1,32'hFFFF_FFF8, 0,32'h0, 32'hFFFF_FFF8, 0));
    tbl.push_back(mk(1,1,0,0, 1,32'hFFFF_FFF8, 32'hFFFF_FFFC, 0));
    tbl.push_back(mk(1,1,0,0, 1,32'hFFFF_FFFC, 32'h0,         0));
    tbl.push_back(mk(1,1,0,0, 1,32'h0,       32'h4,       0));
    // pause: last push while leaving RUN, then drain in IDLE
    tbl.push_back(mk(0,0,0,0, 1,32'h0,       32'h8,       0));
    tbl.push_back(mk(0,0,0,0, 1,32'h0,       32'h8,       0));
    tbl.push_back(mk(0,1,0,0, 1,32'h4,       32'h8,       0));
    tbl.push_back(mk(0,1,0,0, 0,32'h0,       32'h8,       0));
    tbl.push_back(mk(0,1,0,0, 0,32'h0,       32'h8,       0));
    // redirect while IDLE, then restart
    tbl.push_back(mk(0,1,1,32'h100, 0,32'h0, 32'h100,     0));
    tbl.push_back(mk(1,1,0,0, 0,32'h0,       32'h100,     0));
    tbl.push_back(mk(1,1,0,0, 1,32'h100,     32'h104,     0));
    // misaligned redirect traps; later redirects ignored
    tbl.push_back(mk(1,1,1,32'h42, 0,32'h0,  32'h104,     1));
    tbl.push_back(mk(1,1,0,0, 0,32'h0,       32'h104,     1));
    tbl.push_back(mk(1,1,1,32'h200, 0,32'h0, 32'h104,     1));
    tbl.push_back(mk(1,1,0,0, 0,32'h0,       32'h104,     1));

    rst_n = 1'b0; fetch_en = 0; out_ready = 0; redirect_valid = 0; redirect_pc = '0;
    #2;
    expect_out("reset", 0, 0, 32'h0, 32'h0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].fe, tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
      expect_out("vec", i, tbl[i].ov, tbl[i].opc, tbl[i].addr, tbl[i].err);
    end

    // reset pulse clears the trap and restarts at RESET_PC
    rst_n = 1'b0;
    #1;
    expect_out("err_rst", 0, 0, 32'h0, 32'h0, 0);
    #1;
    rst_n = 1'b1;
    step(1, 1, 0, 0);
    expect_out("err_rst", 1, 0, 32'h0, 32'h0, 0);
    step(1, 1, 0, 0);
    expect_out("err_rst", 2, 1, 32'h0, 32'h4, 0);

    // fill the buffer, then assert reset between edges
    step(1, 0, 0, 0);
    expect_out("async", 0, 1, 32'h0, 32'h8, 0);
    step(1, 0, 0, 0);
    expect_out("async", 1, 1, 32'h0, 32'h8, 0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async", 2, 0, 32'h0, 32'h0, 0);
    #1;
    rst_n = 1'b1;
    step(1, 1, 0, 0);
    expect_out("async", 3, 0, 32'h0, 32'h0, 0);
    step(1, 1, 0, 0);
    expect_out("async", 4, 1, 32'h0, 32'h4, 0);
    step(1, 1, 0, 0);
    expect_out("async", 5, 1, 32'h4, 32'h8, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
